alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one combinational 8-bit ALU among NREQ requesters.
- Grants requesters round-robin and registers the result into a single output slot.
- Tags each result with the requester index and holds it under a valid/ready handshake.
- Sits between the per-unit command sources and the shared ALU datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  per-requester command valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
- req_op  input  3*NREQ  opcode of requester i at bits [3i+2:3i].
- req_a  input  8*NREQ  operand A of requester i at bits [8i+7:8i].
- req_b  input  8*NREQ  operand B of requester i at bits [8i+7:8i].
- res_valid  output  1  result slot holds a result.
- res_ready  input  1  downstream accepts the result.
- res_data  output  8  ALU result.
- res_id  output  IDW  index of the requester that produced res_data.

Behaviour:
- Opcodes: 000 add, 001 sub, 010 and, 011 xor, 100 or, 101 nand, 110 nor, 111 xnor.
- All opcodes are 8-bit, modulo 2^8; no carry or flags.
- Reset (rst_n low at a clock edge):
  - res_valid=0, res_data=0, res_id=0, rr_ptr=0.
  - req_ready is 0 while rst_n is low.
  - Reset mid-operation discards any held result; no ready pulse is issued in that cycle.
- Slot state machine:
  - EMPTY (res_valid=0) -> FULL on grant.
  - FULL -> EMPTY when res_ready=1 and there is no grant.
  - FULL -> FULL on simultaneous drain and grant; the new result replaces the old one in the same edge.
- slot_free = !res_valid | res_ready.
- Grant (combinational):
  - If slot_free and any req_valid, grant the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1 only for the granted index g.
  - req_ready does not depend on req_op, req_a or req_b.
- Transfer occurs when req_valid[g] and req_ready[g] are both high at an edge. At that edge:
  - res_data <= ALU(op_g, a_g, b_g)
  - res_id <= g
  - res_valid <= 1
  - rr_ptr <= (g+1) mod NREQ
- Latency:
  - Result is visible one cycle after acceptance.
  - Full throughput is one op per cycle while res_ready stays high.
- Backpressure: with res_valid=1 and res_ready=0, all req_ready=0 and res_data/res_id stay stable.
- Pointer:
  - rr_ptr is unchanged when there is no transfer.
  - Wraps from NREQ-1 to 0.
  - A requester that holds valid is granted within NREQ transfers (no starvation).
- Requester contract: a requester may drop req_valid without a transfer. The arbiter tolerates this with no state change.

Decomposition:
- Package alu_pkg holds:
  - typedef alu_op_t (3 bits) and its eight opcode constants;
  - typedef data_t (8 bits);
  - function alu_eval(op, a, b).
- Sub-module alu_core: purely combinational, operands in, result out, built on alu_eval.
- The arbiter contains the round-robin pick, the slot register and rr_ptr.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, res_valid=0, res_data=0, res_id=0. Release -> first grant goes to index 0.
- Single op: req0 op=000, A=0xF0, B=0x20, res_ready=1 -> next cycle res_valid=1, res_data=0x10 (wrap), res_id=0. Repeat with op=001, A=0x05, B=0x07 -> 0xFE.
- Round robin: all four valid continuously with res_ready=1 -> grants in order 0,1,2,3,0. Each requester uses op=101, A=0xFF, B=0x0F; expect res_data=0xF0 every cycle.
- Backpressure: res_ready=0 while FULL for 3 cycles -> req_ready=0000, res_data/res_id stable. Raise res_ready with req2 valid -> same-edge replacement with req2's result, res_valid stays 1.
- Sparse/pointer: only req3 valid, then only req1 valid -> grant 3, then grant 1. rr_ptr after those two grants = 2.
- Opcode sweep plus mid-op reset: all eight opcodes with A=0xA5, B=0x3C -> E1, 69, 24, 99, BD, DB, 42, 66. Then assert rst_n=0 while FULL -> res_valid=0 next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types, opcode constants and ALU evaluation function for the arbitrated ALU.
// Latency: none, types and a pure function only.
// Backpressure: not applicable.
package alu_pkg;

  typedef logic [2:0] alu_op_t;
  typedef logic [7:0] data_t;

  localparam alu_op_t OP_ADD  = 3'b000;
  localparam alu_op_t OP_SUB  = 3'b001;
  localparam alu_op_t OP_AND  = 3'b010;
  localparam alu_op_t OP_XOR  = 3'b011;
  localparam alu_op_t OP_OR   = 3'b100;
  localparam alu_op_t OP_NAND = 3'b101;
  localparam alu_op_t OP_NOR  = 3'b110;
  localparam alu_op_t OP_XNOR = 3'b111;

  // Result slot occupancy; FULL is exactly res_valid.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // 8-bit modulo arithmetic and bitwise logic; no carry or flags are produced.
  function automatic data_t alu_eval(input alu_op_t op, input data_t a, input data_t b);
    data_t y;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 8-bit ALU.
// Latency: zero cycles, result follows operands combinationally.
// Backpressure: none, no state and no handshake.
module alu_core
  import alu_pkg::*;
(
  input  alu_op_t op,
  input  data_t   a,
  input  data_t   b,
  output data_t   y
);

  assign y = alu_eval(op, a, b);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin shares one ALU among NREQ requesters; result held in one tagged output slot.
// Latency: result visible one cycle after acceptance; one op per cycle while res_ready stays high.
// Backpressure: a full slot with res_ready low blocks every req_ready and freezes res_data/res_id.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output data_t             res_data,
  output logic [IDW-1:0]    res_id
);

  slot_state_t    state;
  logic [IDW-1:0] rr_ptr;
  logic           slot_free;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] scan_id;
  logic [IDW-1:0] next_ptr;
  alu_op_t        op_g;
  data_t          a_g;
  data_t          b_g;
  data_t          alu_y;

  assign res_valid = (state == SLOT_FULL);
  // A draining slot can take a new result on the same edge.
  assign slot_free = (state == SLOT_EMPTY) || res_ready;
  assign next_ptr  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  // Pick the first valid requester starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    scan_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_id = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_vld && req_valid[scan_id]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan_id;
      end
    end
    // No grant while the slot is blocked or reset is asserted.
    if (!rst_n || !slot_free) begin
      gnt_vld = 1'b0;
    end
  end

  // One-hot ready for the granted index only; operand values never affect it.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = gnt_vld && (gnt_id == IDW'(i));
    end
  end

  // Steer the granted requester's opcode and operands into the shared ALU.
  always_comb begin
    op_g = '0;
    a_g  = '0;
    b_g  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        op_g = alu_op_t'(req_op[3*i +: 3]);
        a_g  = req_a[8*i +: 8];
        b_g  = req_b[8*i +: 8];
      end
    end
  end

  alu_core u_alu (
    .op (op_g),
    .a  (a_g),
    .b  (b_g),
    .y  (alu_y)
  );

  // Slot state machine: load on grant (replacing on simultaneous drain), empty on drain alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SLOT_EMPTY;
      res_data <= '0;
      res_id   <= '0;
      rr_ptr   <= '0;
    end else if (gnt_vld) begin
      state    <= SLOT_FULL;
      res_data <= alu_y;
      res_id   <= gnt_id;
      rr_ptr   <= next_ptr;
    end else if (res_ready) begin
      state    <= SLOT_EMPTY;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed scoreboard bench for alu_rr_arbiter (NREQ=4).
// Driver sets inputs 1ns after posedge and pushes hand-computed results; monitor pops on negedge handshakes.
// Direct checks on req_ready and slot hold behaviour are made 3ns after posedge.
module tb_alu_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_data;
  logic [IDW-1:0]    res_id;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_all(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3] = op;
      req_a[8*i +: 8]  = a;
      req_b[8*i +: 8]  = b;
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  task automatic expect_res(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual id=%0d data=%0h expected none at %0t", res_id, res_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_id", 32'(res_id), 32'(e.id));
        chk("res_data", 32'(res_data), 32'(e.data));
      end
    end
  end

  logic [7:0] sweep_exp [8];
  logic [3:0] rr_ready_exp [5];
  logic [1:0] sweep_gnt [8];

  initial begin
    sweep_exp = '{8'hE1, 8'h69, 8'h24, 8'h99, 8'hBD, 8'hDB, 8'h42, 8'h66};
    rr_ready_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    sweep_gnt = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset held with every requester asking.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    step(); step(); step();
    settle();
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_res_valid", 32'(res_valid), 32'h0);
    chk("reset_res_data", 32'(res_data), 32'h0);
    chk("reset_res_id", 32'(res_id), 32'h0);

    // Round robin straight out of reset: 0,1,2,3,0 with nand FF,0F = F0.
    step();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    set_all(3'b101, 8'hFF, 8'h0F);
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("rr_req_ready", 32'(req_ready), 32'(rr_ready_exp[c]));
      expect_res(2'(c % NREQ), 8'hF0);
      step();
    end

    // Single ops on requester 0 (pointer now 1, so the scan wraps round to 0).
    req_valid = 4'b0001;
    set_req(0, 3'b000, 8'hF0, 8'h20);
    settle();
    chk("add_req_ready", 32'(req_ready), 32'h1);
    expect_res(2'd0, 8'h10);
    step();
    set_req(0, 3'b001, 8'h05, 8'h07);
    settle();
    chk("add_latency_valid", 32'(res_valid), 32'h1);
    chk("sub_req_ready", 32'(req_ready), 32'h1);
    expect_res(2'd0, 8'hFE);
    step();

    // Backpressure: slot holds {0,FE}; requester 2 waits.
    res_ready = 1'b0;
    req_valid = 4'b0100;
    set_req(2, 3'b100, 8'h12, 8'h40);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_res_valid", 32'(res_valid), 32'h1);
      chk("bp_res_data", 32'(res_data), 32'hFE);
      chk("bp_res_id", 32'(res_id), 32'h0);
      step();
    end
    // Drain and grant on the same edge.
    res_ready = 1'b1;
    settle();
    chk("replace_req_ready", 32'(req_ready), 32'h4);
    expect_res(2'd2, 8'h52);
    step();
    req_valid = 4'b0000;
    res_ready = 1'b0;
    settle();
    chk("replace_res_valid", 32'(res_valid), 32'h1);
    chk("replace_res_id", 32'(res_id), 32'h2);
    step();
    res_ready = 1'b1;
    step();

    // Sparse: only 3, then only 1; pointer must end at 2.
    req_valid = 4'b1000;
    set_req(3, 3'b000, 8'h01, 8'h02);
    settle();
    chk("sparse3_req_ready", 32'(req_ready), 32'h8);
    expect_res(2'd3, 8'h03);
    step();
    req_valid = 4'b0010;
    set_req(1, 3'b001, 8'h10, 8'h01);
    settle();
    chk("sparse1_req_ready", 32'(req_ready), 32'h2);
    expect_res(2'd1, 8'h0F);
    step();

    // Opcode sweep with all valid; grants continue from pointer 2.
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      set_all(3'(c), 8'hA5, 8'h3C);
      settle();
      chk("sweep_req_ready", 32'(req_ready), 32'(4'b0001 << sweep_gnt[c]));
      expect_res(sweep_gnt[c], sweep_exp[c]);
      step();
    end

    // Hold the last sweep result, then reset mid-operation to discard it.
    req_valid = 4'b0000;
    res_ready = 1'b0;
    settle();
    chk("hold_res_data", 32'(res_data), 32'h66);
    chk("hold_res_id", 32'(res_id), 32'h1);
    void'(exp_q.pop_back());
    step();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    settle();
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    chk("midrst_still_full", 32'(res_valid), 32'h1);
    step();
    settle();
    chk("midrst_res_valid", 32'(res_valid), 32'h0);
    chk("midrst_res_data", 32'(res_data), 32'h0);
    chk("midrst_res_id", 32'(res_id), 32'h0);

    // Pointer returns to 0 after reset.
    step();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    set_all(3'b101, 8'hFF, 8'h0F);
    settle();
    chk("post_rst_req_ready", 32'(req_ready), 32'h1);
    expect_res(2'd0, 8'hF0);
    step();
    req_valid = 4'b0000;
    step();
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
